// File: rtl/fws_pkg.sv
// Shared definitions for the fixed-weight ternary sampler: coefficient
// encodings, FSM states and the index-mask helper.
package fws_pkg;

    localparam logic [1:0] COEF_ZERO  = 2'b00;
    localparam logic [1:0] COEF_PLUS  = 2'b01;
    localparam logic [1:0] COEF_MINUS = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        DRAW,
        RD_I,
        RD_J,
        WR_I,
        WR_J,
        FIN
    } state_t;

    // 2^bitlen(v) - 1: smear the leading one down through all lower bits
    function automatic logic [31:0] bitlen_mask(input logic [31:0] v);
        logic [31:0] m;
        m = v;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction

endpackage

// File: rtl/coef_ram.sv
// P x 2-bit coefficient store: one synchronous write port and one
// synchronous read port with a single cycle of read latency.
module coef_ram #(
    parameter int P    = 677,
    parameter int IDXW = $clog2(P)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [IDXW-1:0] waddr,
    input  logic [1:0]      wdata,
    input  logic [IDXW-1:0] raddr,
    output logic [1:0]      rdata
);

    logic [1:0] mem [P];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fixed_weight_sampler.sv
// Builds a length-P ternary polynomial of exact weight W: deterministic fill
// followed by an in-place Fisher-Yates shuffle with rejection-sampled indices.
module fixed_weight_sampler
    import fws_pkg::*;
#(
    parameter  int P    = 677,
    parameter  int W    = 202,
    parameter  int RW   = 16,
    localparam int IDXW = $clog2(P)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    input  logic [RW-1:0]   rnd_data,
    input  logic            rnd_valid,
    output logic            rnd_ready,
    input  logic [IDXW-1:0] rd_addr,
    output logic [1:0]      rd_data,
    output logic [IDXW-1:0] plus_count,
    output logic [IDXW-1:0] minus_count
);

    localparam logic [IDXW-1:0] LAST = IDXW'(P - 1);
    localparam logic [IDXW-1:0] ONE  = IDXW'(1);
    localparam logic [IDXW:0]   W_L  = (IDXW + 1)'(W);

    state_t          state, state_next;
    logic [IDXW-1:0] i, j, j_cand, fsm_raddr, waddr, ram_raddr;
    logic [1:0]      vi, wdata, ram_q;
    logic            we, in_weight, init_step, draw_ok, ext_valid;
    logic            unused_rnd;

    assign unused_rnd = ^rnd_data;

    always_comb begin
        j_cand    = rnd_data[IDXW-1:0] & IDXW'(bitlen_mask(32'(i)));
        in_weight = {1'b0, i} < W_L;
        init_step = !in_weight || rnd_valid;
        draw_ok   = rnd_valid && (j_cand <= i);
    end

    always_comb begin
        state_next = state;
        rnd_ready  = 1'b0;
        we         = 1'b0;
        waddr      = i;
        wdata      = COEF_ZERO;
        fsm_raddr  = i;
        case (state)
            IDLE: if (start) state_next = INIT;
            FIN:  state_next = start ? INIT : IDLE;
            INIT: begin
                rnd_ready = in_weight;
                we        = init_step;
                if (in_weight) begin
                    wdata = rnd_data[0] ? COEF_MINUS : COEF_PLUS;
                end
                if (init_step && i == LAST) state_next = DRAW;
            end
            DRAW: begin
                rnd_ready = 1'b1;
                if (draw_ok) state_next = RD_I;
            end
            RD_I: state_next = RD_J;
            RD_J: begin
                fsm_raddr  = j;
                state_next = WR_I;
            end
            WR_I: begin
                we         = 1'b1;
                wdata      = ram_q;
                state_next = WR_J;
            end
            WR_J: begin
                we         = 1'b1;
                waddr      = j;
                wdata      = vi;
                state_next = (i == ONE) ? FIN : DRAW;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i           <= '0;
            j           <= '0;
            vi          <= COEF_ZERO;
            busy        <= 1'b0;
            done        <= 1'b0;
            plus_count  <= '0;
            minus_count <= '0;
            ext_valid   <= 1'b0;
        end else begin
            ext_valid <= !busy;
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        i           <= '0;
                        plus_count  <= '0;
                        minus_count <= '0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                INIT: begin
                    if (init_step) begin
                        if (in_weight) begin
                            if (rnd_data[0]) minus_count <= minus_count + ONE;
                            else             plus_count  <= plus_count + ONE;
                        end
                        if (i != LAST) i <= i + ONE;
                    end
                end
                DRAW: if (draw_ok) j <= j_cand;
                RD_J: vi <= ram_q;
                WR_J: begin
                    if (i == ONE) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        i <= i - ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // The FSM owns the RAM read port while busy; external reads are masked
    // until a read issued with busy low has come back.
    assign ram_raddr = busy ? fsm_raddr : rd_addr;
    assign rd_data   = (ext_valid && !busy) ? ram_q : COEF_ZERO;

    coef_ram #(.P(P), .IDXW(IDXW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_fixed_weight_sampler.sv
// Self-checking bench: two sampler instances (P=8/W=3 and default) driven by
// directed and random word streams, checked against a Fisher-Yates model.
module tb_fixed_weight_sampler;
    import fws_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_s = 1'b0, start_d = 1'b0;
    logic [15:0] rnd_data = '0;
    logic        rnd_valid = 1'b0;
    logic [9:0]  rd_addr = '0;

    logic        busy_s, done_s, rdy_s;
    logic [1:0]  rdd_s;
    logic [2:0]  pc_s, mc_s;
    logic        busy_d, done_d, rdy_d;
    logic [1:0]  rdd_d;
    logic [9:0]  pc_d, mc_d;

    always #5 clk = ~clk;

    fixed_weight_sampler #(.P(8), .W(3), .RW(16)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy_s), .done(done_s),
        .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rdy_s),
        .rd_addr(rd_addr[2:0]), .rd_data(rdd_s),
        .plus_count(pc_s), .minus_count(mc_s)
    );

    fixed_weight_sampler #(.P(677), .W(202), .RW(16)) dut_d (
        .clk(clk), .rst_n(rst_n), .start(start_d), .busy(busy_d), .done(done_d),
        .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rdy_d),
        .rd_addr(rd_addr), .rd_data(rdd_d),
        .plus_count(pc_d), .minus_count(mc_d)
    );

    int          n_assert = 0;
    int          n_fail = 0;
    logic [15:0] wq[$];
    int          hs_cyc[$];
    int          done_cyc;
    bit          done_seen;
    int          exp_coef[677];
    int          exp_plus, exp_minus, exp_k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic sel_busy(input bit big); return big ? busy_d : busy_s; endfunction
    function automatic logic sel_done(input bit big); return big ? done_d : done_s; endfunction
    function automatic logic sel_rdy(input bit big);  return big ? rdy_d : rdy_s;   endfunction
    function automatic logic [1:0] sel_rdd(input bit big); return big ? rdd_d : rdd_s; endfunction
    function automatic logic [9:0] sel_pc(input bit big); return big ? pc_d : {7'b0, pc_s}; endfunction
    function automatic logic [9:0] sel_mc(input bit big); return big ? mc_d : {7'b0, mc_s}; endfunction

    function automatic logic [1:0] enc(input int v);
        return (v > 0) ? 2'b01 : (v < 0) ? 2'b11 : 2'b00;
    endfunction

    // Reference: weighted fill, then Fisher-Yates with rejection on the word stream
    task automatic model(input int p, input int w);
        int k, j, m, t;
        k = 0; exp_plus = 0; exp_minus = 0;
        for (int n = 0; n < p; n++) begin
            if (n < w) begin
                if (wq[k][0]) begin exp_coef[n] = -1; exp_minus++; end
                else          begin exp_coef[n] = 1;  exp_plus++;  end
                k++;
            end else begin
                exp_coef[n] = 0;
            end
        end
        for (int i = p - 1; i >= 1; i--) begin
            m = 1;
            while (m < i) m = (m << 1) | 1;
            j = int'(wq[k]) & m; k++;
            while (j > i) begin j = int'(wq[k]) & m; k++; end
            t = exp_coef[i]; exp_coef[i] = exp_coef[j]; exp_coef[j] = t;
        end
        exp_k = k;
    endtask

    task automatic chk_reset(input bit big);
        chk("rst_busy", sel_busy(big), 0);
        chk("rst_done", sel_done(big), 0);
        chk("rst_ready", sel_rdy(big), 0);
        chk("rst_rd_data", sel_rdd(big), 0);
        chk("rst_plus", sel_pc(big), 0);
        chk("rst_minus", sel_mc(big), 0);
    endtask

    task automatic run_gen(input bit big, input int gap, input int abort_after,
                           input int poke_at, input int limit);
        int k, c, gcnt;
        bit rdy_prev, val_prev;
        k = 0; c = 0; gcnt = gap; rdy_prev = 0; val_prev = 0;
        hs_cyc.delete(); done_seen = 0; done_cyc = 0;
        @(negedge clk);
        if (big) start_d = 1'b1; else start_s = 1'b1;
        rnd_valid = 1'b0;
        @(negedge clk);
        start_d = 1'b0; start_s = 1'b0; c = 1;
        chk("busy_after_start", sel_busy(big), 1);
        chk("done_clear_after_start", sel_done(big), 0);
        while (c < limit) begin
            if (c > 1) begin
                if (rdy_prev && val_prev) begin
                    k++; hs_cyc.push_back(c - 1); gcnt = gap;
                end else if (gap > 0 && rdy_prev) begin
                    chk("ready_held_while_stalled", sel_rdy(big), 1);
                end
                if (sel_done(big)) begin done_seen = 1; done_cyc = c; break; end
                if (gap > 0) chk("busy_held", sel_busy(big), 1);
                if (k == abort_after) break;
            end
            if (big) start_d = (c == poke_at); else start_s = (c == poke_at);
            if (gcnt > 0) begin
                rnd_valid = 1'b0; gcnt--;
            end else if (k < wq.size()) begin
                rnd_valid = 1'b1; rnd_data = wq[k];
            end else begin
                rnd_valid = 1'b0;
            end
            rdy_prev = sel_rdy(big); val_prev = rnd_valid;
            c++;
            @(negedge clk);
        end
        rnd_valid = 1'b0; start_d = 1'b0; start_s = 1'b0;
        if (abort_after < 0) chk("done_within_budget", done_seen, 1);
    endtask

    task automatic check_result(input bit big, input int p, input int w, input bit timed);
        int nz, np;
        logic [1:0] d;
        nz = 0; np = 0;
        chk("words_consumed", hs_cyc.size(), exp_k);
        if (timed) chk("done_latency", done_cyc - 1, p + 4 * (p - 1) + exp_k - w);
        chk("busy_low_at_done", sel_busy(big), 0);
        chk("plus_count", sel_pc(big), exp_plus);
        chk("minus_count", sel_mc(big), exp_minus);
        for (int a = 0; a <= p; a++) begin
            @(negedge clk);
            if (a > 0) begin
                d = sel_rdd(big);
                chk($sformatf("coef[%0d]", a - 1), d, enc(exp_coef[a - 1]));
                if (d != 2'b00) nz++;
                if (d == COEF_PLUS) np++;
            end
            if (a < p) rd_addr = 10'(a);
        end
        chk("weight_readback", nz, w);
        chk("plus_readback_vs_count", np, sel_pc(big));
    endtask

    task automatic load_test1();
        logic [15:0] t1[11] = '{16'd0, 16'd1, 16'd0, 16'd0, 16'd7, 16'd1,
                                16'd5, 16'd2, 16'd0, 16'd2, 16'd1};
        wq.delete();
        foreach (t1[n]) wq.push_back(t1[n]);
    endtask

    task automatic load_random(input int n_init, input int n_draw);
        wq.delete();
        for (int n = 0; n < n_init + n_draw; n++) wq.push_back(16'($urandom()));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed stream, no stalls
        load_test1(); model(8, 3);
        run_gen(0, 0, -1, -1, 2000);
        check_result(0, 8, 3, 1);

        // Same stream with five idle cycles before each word
        load_test1(); model(8, 3);
        run_gen(0, 5, -1, -1, 2000);
        check_result(0, 8, 3, 0);

        // Reset in the middle of DRAW, then a clean rerun
        load_test1(); model(8, 3);
        run_gen(0, 0, 5, -1, 2000);
        rst_n = 1'b0;
        #1;
        chk_reset(0);
        @(negedge clk);
        rst_n = 1'b1;
        run_gen(0, 0, -1, -1, 2000);
        check_result(0, 8, 3, 1);

        // start pulsed while busy is ignored
        load_test1(); model(8, 3);
        run_gen(0, 0, -1, 20, 2000);
        check_result(0, 8, 3, 1);

        // start while done is high restarts on a fresh random stream
        chk("done_held_before_restart", done_s, 1);
        load_random(3, 60); model(8, 3);
        run_gen(0, 0, -1, -1, 2000);
        check_result(0, 8, 3, 1);

        // Default configuration, random stream
        load_random(202, 3000); model(677, 202);
        run_gen(1, 0, -1, -1, 30000);
        check_result(1, 677, 202, 1);

        // First draw at i=676: 0x03FF rejected, 0x0005 accepted
        load_random(202, 0);
        wq.push_back(16'h03FF);
        wq.push_back(16'h0005);
        for (int n = 0; n < 3000; n++) wq.push_back(16'($urandom()));
        model(677, 202);
        run_gen(1, 0, -1, -1, 30000);
        if (hs_cyc.size() > 204) begin
            chk("reject_then_retry_gap", hs_cyc[203] - hs_cyc[202], 1);
            chk("accept_then_swap_gap", hs_cyc[204] - hs_cyc[203], 5);
        end else begin
            chk("draw_handshakes_seen", hs_cyc.size(), 205);
        end
        check_result(1, 677, 202, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
